// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative MIPS MULT/MULTU/DIV/DIVU engine with HI/LO registers
//
// Purpose: multi-cycle multiply/divide for the EX stage. Works on unsigned
// magnitudes, one bit per clock over WIDTH iterations, then applies sign
// correction and writes HI/LO in a single FINISH cycle.
//
// Ports:
//   i_clk     rising-edge clock
//   i_reset   asynchronous active-high reset, clears all state
//   i_start   launch an operation (sampled only while o_busy=0)
//   i_op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_a       rs operand (multiplicand / dividend)
//   i_b       rt operand (multiplier / divisor)
//   i_mthi    HI <= i_wdata (ignored while busy)
//   i_mtlo    LO <= i_wdata (ignored while busy)
//   i_wdata   data for MTHI/MTLO
//   o_hi      product upper half / remainder
//   o_lo      product lower half / quotient
//   o_busy    operation in flight
//   o_done    one-cycle pulse when HI/LO take a new result
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CW-1:0]      r_count;
  logic               r_is_div;
  logic               r_neg_q;     // product / quotient must be negated
  logic               r_neg_r;     // remainder must be negated (dividend negative)
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_a_orig;    // raw dividend, returned as HI on divide by zero
  // Multiply: upper half accumulates, lower half holds the multiplier being shifted out.
  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_accept;
  logic               w_signed_op;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH-1:0]   w_div_sub;
  logic               w_div_ok;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_accept    = (r_state == ST_IDLE) && i_start;
  assign w_signed_op = ~i_op[0];
  assign w_a_neg     = w_signed_op & i_a[WIDTH-1];
  assign w_b_neg     = w_signed_op & i_b[WIDTH-1];
  assign w_abs_a     = w_a_neg ? -i_a : i_a;
  assign w_abs_b     = w_b_neg ? -i_b : i_b;

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the whole accumulator right, keeping the carry.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: shift in the next dividend bit; subtract divisor if it fits.
  // When it fits the difference is below the divisor, so WIDTH bits suffice.
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ok    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;
  assign w_div_next  = w_div_ok ? {w_div_sub, r_acc[WIDTH-2:0], 1'b1}
                                : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_prod_neg = -r_acc;

  always_comb begin
    w_res_hi = r_acc[2*WIDTH-1:WIDTH];
    w_res_lo = r_acc[WIDTH-1:0];
    if (!r_is_div) begin
      if (r_neg_q) begin
        w_res_hi = w_prod_neg[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_neg[WIDTH-1:0];
      end
    end else if (r_div_zero) begin
      w_res_hi = r_a_orig;
      w_res_lo = '1;
    end else begin
      // MIN / -1 lands here too: negating 0x80..0 yields 0x80..0, no trap.
      if (r_neg_q) w_res_lo = -r_acc[WIDTH-1:0];
      if (r_neg_r) w_res_hi = -r_acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_next = ST_CALC;
      ST_CALC:   if (r_count == CW'(WIDTH - 1)) w_state_next = ST_FINISH;
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_opnd     <= '0;
      r_a_orig   <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // MTHI/MTLO on the accepting edge still land; FINISH overwrites later.
          if (i_mthi) r_hi <= i_wdata;
          if (i_mtlo) r_lo <= i_wdata;
          if (w_accept) begin
            r_count    <= '0;
            r_is_div   <= i_op[1];
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div_zero <= (i_b == '0);
            r_a_orig   <= i_a;
            if (i_op[1]) begin
              r_opnd <= w_abs_b;
              r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
            end else begin
              r_opnd <= w_abs_a;
              r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
            end
          end
        end
        ST_CALC: begin
          r_count <= r_count + CW'(1);
          r_acc   <= r_is_div ? w_div_next : w_mul_next;
        end
        ST_FINISH: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_done  <= 1'b1;
          r_count <= '0;
        end
        default: r_count <= '0;
      endcase
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = (r_state != ST_IDLE);
  assign o_done = r_done;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_mthi;
  logic        i_mtlo;
  logic [31:0] i_wdata;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] m_hilo   = 64'h0;  // expected {HI, LO}

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_mthi  (i_mthi),
    .i_mtlo  (i_mtlo),
    .i_wdata (i_wdata),
    .o_hi    (o_hi),
    .o_lo    (o_lo),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: architectural MIPS semantics in plain arithmetic. Returns {HI, LO}.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [63:0]        up;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        sp = 64'(sa) * 64'(sb);
        return sp;
      end
      2'b01: begin
        up = {32'h0, a} * {32'h0, b};
        return up;
      end
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    i_start = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    @(negedge clk);
    i_start = 1'b0;
    i_op    = 2'($urandom);
    i_a     = $urandom;
    i_b     = $urandom;
  endtask

  // n0 = negedges already elapsed since the accepting edge. Returns at the Done negedge.
  task automatic wait_result(input string tag, input logic [63:0] exp, input int n0);
    int n;
    bit busy_ok;
    bit stable_ok;
    n = n0;
    busy_ok = 1'b1;
    stable_ok = 1'b1;
    while (!o_done && n < 40) begin
      if (!o_busy) busy_ok = 1'b0;
      if ({o_hi, o_lo} !== m_hilo) stable_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
    check({tag, "_hilo_stable"}, 64'(stable_ok), 64'd1);
    check({tag, "_busy_at_done"}, 64'(o_busy), 64'd0);
    check({tag, "_result"}, {o_hi, o_lo}, exp);
    m_hilo = exp;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    launch(op, a, b);
    wait_result(tag, exp, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(o_done), 64'd0);
  endtask

  initial begin
    bit          quiet;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    i_reset = 1'b1;
    i_start = 1'b0;
    i_op    = 2'b00;
    i_a     = 32'h0;
    i_b     = 32'h0;
    i_mthi  = 1'b0;
    i_mtlo  = 1'b0;
    i_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_hilo", {o_hi, o_lo}, 64'h0);
    check("reset_busy_done", {62'h0, o_busy, o_done}, 64'h0);
    i_reset = 1'b0;
    @(negedge clk);

    // MTHI / MTLO in IDLE, separately and together
    i_mthi = 1'b1; i_wdata = 32'h1234;
    @(negedge clk);
    i_mthi = 1'b0;
    check("mthi", {o_hi, o_lo}, {32'h1234, 32'h0});
    i_mtlo = 1'b1; i_wdata = 32'h5678;
    @(negedge clk);
    i_mtlo = 1'b0;
    check("mtlo", {o_hi, o_lo}, {32'h1234, 32'h5678});
    i_mthi = 1'b1; i_mtlo = 1'b1; i_wdata = 32'h9ABC;
    @(negedge clk);
    i_mthi = 1'b0; i_mtlo = 1'b0;
    check("mthi_mtlo", {o_hi, o_lo}, {32'h9ABC, 32'h9ABC});
    m_hilo = {32'h9ABC, 32'h9ABC};

    // Reset mid-CALC discards the operation
    launch(2'b01, 32'd5, 32'd7);
    repeat (9) @(negedge clk);
    #2 i_reset = 1'b1;
    #1;
    check("midreset_hilo", {o_hi, o_lo}, 64'h0);
    check("midreset_busy", 64'(o_busy), 64'd0);
    @(negedge clk);
    i_reset = 1'b0;
    m_hilo = 64'h0;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (o_done || o_busy) quiet = 1'b0;
    end
    check("midreset_quiet", 64'(quiet), 64'd1);
    check("midreset_hilo_after", {o_hi, o_lo}, 64'h0);

    // Directed corner cases
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0});
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run_op("divu_by0", 2'b11, 32'd42, 32'd0, {32'd42, 32'hFFFF_FFFF});
    run_op("div_by0", 2'b10, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF});

    // MTHI and a second Start while busy are both ignored
    launch(2'b11, 32'd1000, 32'd33);
    repeat (4) @(negedge clk);
    i_mthi = 1'b1; i_wdata = 32'hDEAD_BEEF;
    i_start = 1'b1; i_op = 2'b01; i_a = 32'd3; i_b = 32'd3;
    @(negedge clk);
    i_mthi = 1'b0; i_start = 1'b0;
    wait_result("busy_ignore", {32'd10, 32'd30}, 5);
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (o_busy || o_done) quiet = 1'b0;
    end
    check("busy_ignore_no_queue", 64'(quiet), 64'd1);

    // Start at the edge right after Done, with MTLO on the accepting edge
    launch(2'b01, 32'd6, 32'd9);
    wait_result("b2b_first", {32'h0, 32'd54}, 0);
    i_mtlo = 1'b1; i_wdata = 32'h55;
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    i_mtlo = 1'b0;
    check("b2b_done_low", 64'(o_done), 64'd0);
    check("b2b_accepted", 64'(o_busy), 64'd1);
    check("b2b_mtlo_applied", {o_hi, o_lo}, {32'h0, 32'h55});
    m_hilo = {32'h0, 32'h55};
    wait_result("b2b_second", {32'h0, 32'h1}, 0);
    @(negedge clk);

    // Randomized operations against the reference model
    for (int k = 0; k < 24; k++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'($urandom_range(0, 255));
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op($sformatf("rand%0d_op%0d", k, op), op, a, b, ref_model(op, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
